// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note indices, half-period table and FSM state type for the tone generator
package piano_pkg;

   localparam int NUM_NOTES     = 8;
   localparam int CNT_W_DEFAULT = 17;

   localparam logic [2:0] NOTE_C  = 3'd0;
   localparam logic [2:0] NOTE_D  = 3'd1;
   localparam logic [2:0] NOTE_E  = 3'd2;
   localparam logic [2:0] NOTE_F  = 3'd3;
   localparam logic [2:0] NOTE_G  = 3'd4;
   localparam logic [2:0] NOTE_A  = 3'd5;
   localparam logic [2:0] NOTE_B  = 3'd6;
   localparam logic [2:0] NOTE_C2 = 3'd7;

   // Half-period in 50 MHz clocks, C4 up to C5
   localparam int unsigned HP_TABLE [NUM_NOTES] = '{
      95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778
   };

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

endpackage

// File: rtl/note_prio_enc.sv
// rtl/note_prio_enc.sv - highest-set-bit encoder selecting the highest-pitch active note
module note_prio_enc
   import piano_pkg::*;
(
   input  logic [NUM_NOTES-1:0] en,
   output logic [2:0]           sel,
   output logic                 any_en
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (en[i]) sel = 3'(i);
      end
   end

   assign any_en = |en;

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - single-voice square-wave generator; pitch and stop changes land only on half-period boundaries
module note_tone_gen
   import piano_pkg::*;
#(
   parameter int SIM_SHIFT = 0,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_NOTES-1:0] note_en,
   output logic                 audio_out,
   output logic                 playing,
   output logic [2:0]           note_idx
);

   logic [NUM_NOTES-1:0] sync1_q, sync1_d;
   logic [NUM_NOTES-1:0] sync2_q, sync2_d;
   state_t               state_q, state_d;
   logic                 audio_q, audio_d;
   logic                 playing_q, playing_d;
   logic [2:0]           idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     hp_m1;
   logic [2:0]           sel;
   logic                 any_en;

   // Tiny SIM_SHIFT-scaled values are clamped so a half is never shorter than 2 clocks
   function automatic logic [CNT_W-1:0] half_period(input logic [2:0] i);
      logic [CNT_W-1:0] v;
      v = CNT_W'(HP_TABLE[i] >> SIM_SHIFT);
      if (v < CNT_W'(2)) v = CNT_W'(2);
      return v;
   endfunction

   note_prio_enc u_prio (
      .en     (sync2_q),
      .sel    (sel),
      .any_en (any_en)
   );

   always_comb begin
      sync1_d = note_en;
      sync2_d = sync1_q;
      state_d = state_q;
      audio_d = audio_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      hp_m1   = half_period(sel) - CNT_W'(1);
      case (state_q)
         IDLE: begin
            audio_d = 1'b0;
            if (any_en) begin
               state_d = PLAY;
               audio_d = 1'b1;
               idx_d   = sel;
               cnt_d   = hp_m1;
            end
         end
         PLAY: begin
            if (cnt_q == '0) begin
               if (any_en) begin
                  audio_d = ~audio_q;
                  idx_d   = sel;
                  cnt_d   = hp_m1;
               end else begin
                  audio_d = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      playing_d = (state_d == PLAY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         state_q   <= IDLE;
         audio_q   <= 1'b0;
         playing_q <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         audio_q   <= audio_d;
         playing_q <= playing_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
      end
   end

   assign audio_out = audio_q;
   assign playing   = playing_q;
   assign note_idx  = idx_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - scoreboard bench measuring square-wave half lengths and note indices
module tb_note_tone_gen;

   localparam int SHIFT = 10;
   localparam int HP_C4 = 95556 >> SHIFT;
   localparam int HP_G4 = 63776 >> SHIFT;
   localparam int HP_A4 = 56818 >> SHIFT;
   localparam int HP_C5 = 47778 >> SHIFT;
   localparam int BOUND = 3000;

   typedef struct {
      logic       lvl;
      int         len;
      logic [2:0] idx;
      logic       play;
   } run_t;

   logic       clk;
   logic       rst;
   logic [7:0] note_en;
   logic       audio_out;
   logic       playing;
   logic [2:0] note_idx;

   int total;
   int bad;

   run_t obs_q[$];
   run_t exp_q[$];

   logic       cur_lvl;
   int         cur_len;
   logic [2:0] cur_idx;
   logic       cur_play;
   logic       prev_play;
   int         rel_len;

   note_tone_gen #(.SIM_SHIFT(SHIFT), .CNT_W(17)) dut (
      .clk       (clk),
      .rst       (rst),
      .note_en   (note_en),
      .audio_out (audio_out),
      .playing   (playing),
      .note_idx  (note_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run-length monitor: each finished level run of audio_out is pushed to obs_q
   always @(negedge clk) begin
      if (rst) begin
         cur_lvl   = 1'b0;
         cur_len   = 0;
         cur_idx   = '0;
         cur_play  = 1'b0;
         prev_play = 1'b0;
      end else begin
         if (prev_play && !playing) rel_len = cur_len;
         if (audio_out === cur_lvl) begin
            cur_len++;
         end else begin
            if (cur_len > 0) obs_q.push_back('{cur_lvl, cur_len, cur_idx, cur_play});
            cur_lvl  = audio_out;
            cur_len  = 1;
            cur_idx  = note_idx;
            cur_play = playing;
         end
         prev_play = playing;
      end
   end

   task automatic wait_runs(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk); #1;
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Leaves the bench at the first sample of a fresh run of level lvl while playing
   task automatic align(input logic lvl, output bit ok);
      ok = 1'b0;
      obs_q.delete();
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk); #1;
         if (obs_q.size() > 0) begin
            obs_q.delete();
            if (audio_out === lvl && playing === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      note_en = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (audio_out !== 1'b0 || playing !== 1'b0 || note_idx !== 3'd0) begin
         bad++;
         $display("FAIL reset_init: audio=%b playing=%b idx=%0d expected 0 0 0", audio_out, playing, note_idx);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      note_en = 8'h01;
      repeat (40) @(posedge clk);
      #3;
      total++;
      if (audio_out !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_tone: audio=%b expected 1", audio_out);
      end
      rst = 1'b1;
      #1;
      total++;
      if (audio_out !== 1'b0 || playing !== 1'b0 || note_idx !== 3'd0) begin
         bad++;
         $display("FAIL reset_async: audio=%b playing=%b idx=%0d expected 0 0 0", audio_out, playing, note_idx);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (audio_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_latency_early: audio=%b expected 0 after 2 edges", audio_out);
      end
      @(posedge clk); #1;
      total++;
      if (audio_out !== 1'b1 || playing !== 1'b1) begin
         bad++;
         $display("FAIL reset_latency: audio=%b playing=%b expected 1 1 after 3 edges", audio_out, playing);
      end
   endtask

   task automatic test_single_note;
      bit ok;
      run_t e, o;
      align(1'b1, ok);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{1'b1, HP_C4, 3'd0, 1'b1});
         exp_q.push_back('{1'b0, HP_C4, 3'd0, 1'b1});
      end
      wait_runs(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL single_timeout: runs=%0d expected 4", obs_q.size());
         obs_q.delete();
         exp_q.delete();
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o.lvl !== e.lvl || o.len !== e.len || o.idx !== e.idx || o.play !== e.play) begin
            bad++;
            $display("FAIL single_run: got lvl=%b len=%0d idx=%0d play=%b expected lvl=%b len=%0d idx=%0d play=%b",
                     o.lvl, o.len, o.idx, o.play, e.lvl, e.len, e.idx, e.play);
         end
      end
   endtask

   task automatic test_priority;
      bit ok;
      run_t e, o;
      @(posedge clk); #1;
      note_en = 8'h30;
      repeat (5) @(posedge clk);
      align(1'b1, ok);
      exp_q.push_back('{1'b1, HP_A4, 3'd5, 1'b1});
      exp_q.push_back('{1'b0, HP_A4, 3'd5, 1'b1});
      wait_runs(2, ok);
      @(posedge clk); #1;
      note_en = 8'hB0;
      exp_q.push_back('{1'b1, HP_A4, 3'd5, 1'b1});
      exp_q.push_back('{1'b0, HP_C5, 3'd7, 1'b1});
      exp_q.push_back('{1'b1, HP_C5, 3'd7, 1'b1});
      wait_runs(5, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL priority_timeout: runs=%0d expected 5", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o.lvl !== e.lvl || o.len !== e.len || o.idx !== e.idx || o.play !== e.play) begin
            bad++;
            $display("FAIL priority_run: got lvl=%b len=%0d idx=%0d play=%b expected lvl=%b len=%0d idx=%0d play=%b",
                     o.lvl, o.len, o.idx, o.play, e.lvl, e.len, e.idx, e.play);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_glitch_free;
      bit ok;
      run_t e, o;
      @(posedge clk); #1;
      note_en = 8'h01;
      repeat (5) @(posedge clk);
      align(1'b1, ok);
      repeat (29) @(posedge clk);
      #1;
      note_en = 8'h10;
      exp_q.push_back('{1'b1, HP_C4, 3'd0, 1'b1});
      exp_q.push_back('{1'b0, HP_G4, 3'd4, 1'b1});
      exp_q.push_back('{1'b1, HP_G4, 3'd4, 1'b1});
      wait_runs(3, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL glitch_timeout: runs=%0d expected 3", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o.lvl !== e.lvl || o.len !== e.len || o.idx !== e.idx || o.play !== e.play) begin
            bad++;
            $display("FAIL glitch_run: got lvl=%b len=%0d idx=%0d play=%b expected lvl=%b len=%0d idx=%0d play=%b",
                     o.lvl, o.len, o.idx, o.play, e.lvl, e.len, e.idx, e.play);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_release;
      bit ok;
      run_t e, o;
      @(posedge clk); #1;
      note_en = 8'h20;
      repeat (5) @(posedge clk);
      align(1'b1, ok);
      repeat (9) @(posedge clk);
      #1;
      note_en = 8'h00;
      exp_q.push_back('{1'b1, HP_A4, 3'd5, 1'b1});
      wait_runs(1, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL release_high_timeout: runs=%0d expected 1", obs_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.lvl !== e.lvl || o.len !== e.len || o.idx !== e.idx) begin
            bad++;
            $display("FAIL release_high_run: got lvl=%b len=%0d idx=%0d expected lvl=%b len=%0d idx=%0d",
                     o.lvl, o.len, o.idx, e.lvl, e.len, e.idx);
         end
      end
      exp_q.delete();
      total++;
      if (audio_out !== 1'b0 || playing !== 1'b0) begin
         bad++;
         $display("FAIL release_high_stop: audio=%b playing=%b expected 0 0", audio_out, playing);
      end
      repeat (200) @(negedge clk);
      #1;
      total++;
      if (obs_q.size() != 0 || audio_out !== 1'b0 || playing !== 1'b0) begin
         bad++;
         $display("FAIL release_high_silent: runs=%0d audio=%b playing=%b expected 0 0 0", obs_q.size(), audio_out, playing);
      end

      @(posedge clk); #1;
      note_en = 8'h20;
      repeat (5) @(posedge clk);
      align(1'b0, ok);
      rel_len = -1;
      repeat (9) @(posedge clk);
      #1;
      note_en = 8'h00;
      ok = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk); #1;
         if (rel_len != -1) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok || rel_len != HP_A4) begin
         bad++;
         $display("FAIL release_low_len: low half=%0d expected %0d", rel_len, HP_A4);
      end
      repeat (100) @(negedge clk);
      #1;
      total++;
      if (obs_q.size() != 0 || audio_out !== 1'b0 || playing !== 1'b0) begin
         bad++;
         $display("FAIL release_low_silent: runs=%0d audio=%b playing=%b expected 0 0 0", obs_q.size(), audio_out, playing);
      end
   endtask

   task automatic test_short_pulse;
      bit ok;
      run_t e, o;
      @(posedge clk); #1;
      note_en = 8'h80;
      repeat (3) @(posedge clk);
      #1;
      note_en = 8'h00;
      ok = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk); #1;
         if (audio_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      obs_q.delete();
      exp_q.push_back('{1'b1, HP_C5, 3'd7, 1'b1});
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL pulse_start: audio=%b expected 1", audio_out);
      end
      wait_runs(1, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL pulse_timeout: runs=%0d expected 1", obs_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.lvl !== e.lvl || o.len !== e.len || o.idx !== e.idx || o.play !== e.play) begin
            bad++;
            $display("FAIL pulse_run: got lvl=%b len=%0d idx=%0d play=%b expected lvl=%b len=%0d idx=%0d play=%b",
                     o.lvl, o.len, o.idx, o.play, e.lvl, e.len, e.idx, e.play);
         end
      end
      exp_q.delete();
      repeat (200) @(negedge clk);
      #1;
      total++;
      if (obs_q.size() != 0 || audio_out !== 1'b0 || playing !== 1'b0 || note_idx !== 3'd7) begin
         bad++;
         $display("FAIL pulse_silent: runs=%0d audio=%b playing=%b idx=%0d expected 0 0 0 7",
                  obs_q.size(), audio_out, playing, note_idx);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rel_len = -1;
      rst = 1'b1;
      note_en = 8'h00;
      test_reset();
      test_single_note();
      test_priority();
      test_glitch_free();
      test_release();
      test_short_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
